// File: rtl/imem_loader.sv
// Boot loader: assembles a little-endian byte stream into words, writes them to instruction
// memory and holds the core in reset until the image is in. Optional IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  error
);

    localparam logic [31:0] MAX_WORDS = 32'(2 ** (ADDR_WIDTH - 2));

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_LEN, S_DATA, S_CHK, S_RUN, S_ERR} state_t;
    localparam state_t AFTER_DATA = S_CHK;
`else
    typedef enum logic [2:0] {S_LEN, S_DATA, S_RUN, S_ERR} state_t;
    localparam state_t AFTER_DATA = S_RUN;
`endif

    state_t                  state;
    state_t                  state_next;
    logic [1:0]              byte_cnt;
    logic [23:0]             asm_lo;
    logic [ADDR_WIDTH-2:0]   word_idx;
    logic [31:0]             len;
    logic                    take;
    logic                    last_byte;
    logic [DATA_WIDTH-1:0]   word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]             acc;
`endif

    // The fourth byte completes a word in the same cycle it arrives, so use it directly.
    assign take      = in_valid & in_ready;
    assign last_byte = take && (byte_cnt == 2'd3);
    assign word      = {in_data, asm_lo};

    always_ff @(posedge clk) begin
        if (rst) state <= S_LEN;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_LEN: begin
                if (last_byte) begin
                    if (word > MAX_WORDS)  state_next = S_ERR;
                    else if (word == '0)   state_next = AFTER_DATA;
                    else                   state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (last_byte && (32'(word_idx) == len - 32'd1)) state_next = AFTER_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (last_byte) state_next = (word == acc) ? S_RUN : S_ERR;
            end
`endif
            default: state_next = state;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        case (state)
            S_LEN, S_DATA: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK:         in_ready = 1'b1;
`endif
            default:       in_ready = 1'b0;
        endcase
    end

    // Datapath and registered outputs; cpu_rst/done/error lag the state by one cycle so the
    // final write strobe always lands before the core leaves reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt   <= '0;
            asm_lo     <= '0;
            word_idx   <= '0;
            len        <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc        <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            cpu_rst <= (state != S_RUN);
            done    <= (state == S_RUN);
            error   <= (state == S_ERR);
            if (take) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0:    asm_lo[7:0]   <= in_data;
                    2'd1:    asm_lo[15:8]  <= in_data;
                    2'd2:    asm_lo[23:16] <= in_data;
                    default: ;
                endcase
            end
            if (last_byte && (state == S_LEN)) len <= word;
            if (last_byte && (state == S_DATA)) begin
                imem_we    <= 1'b1;
                imem_addr  <= {word_idx[ADDR_WIDTH-3:0], 2'b00};
                imem_wdata <= word;
                word_idx   <= word_idx + (ADDR_WIDTH - 1)'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                acc        <= acc + word;
`endif
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a negedge monitor pops expected writes from a
// scoreboard queue filled as each image is built; scenario tasks check control outputs inline.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [11:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        error;

    int n_compared;
    int n_mismatched;

    logic [7:0]  img[$];
    logic [43:0] sb[$];

    imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every write strobe must match the oldest expected {addr, data} entry.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            n_compared++;
            if (sb.size() == 0) begin
                n_mismatched++;
                $display("[TB] FAIL unexpected_write: got addr=%h data=%h, required no write", imem_addr, imem_wdata);
            end else begin
                logic [43:0] exp;
                exp = sb.pop_front();
                if ({imem_addr, imem_wdata} !== exp) begin
                    n_mismatched++;
                    $display("[TB] FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             imem_addr, imem_wdata, exp[43:32], exp[31:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic push_word(input logic [31:0] w);
        img.push_back(w[7:0]);
        img.push_back(w[15:8]);
        img.push_back(w[23:16]);
        img.push_back(w[31:24]);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL send_timeout: in_ready=%b, required 1", in_ready);
            in_valid = 1'b0;
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic send_image(input int max_gap);
        for (int i = 0; i < img.size(); i++)
            send_byte(img[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
        in_valid = 1'b0;
        img.delete();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_compared += 7;
        if (imem_we !== 1'b0)     begin n_mismatched++; $display("[TB] FAIL reset_we: got %b, required 0", imem_we); end
        if (imem_addr !== 12'h0)  begin n_mismatched++; $display("[TB] FAIL reset_addr: got %h, required 000", imem_addr); end
        if (imem_wdata !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_wdata: got %h, required 0", imem_wdata); end
        if (cpu_rst !== 1'b1)     begin n_mismatched++; $display("[TB] FAIL reset_cpu_rst: got %b, required 1", cpu_rst); end
        if (done !== 1'b0)        begin n_mismatched++; $display("[TB] FAIL reset_done: got %b, required 0", done); end
        if (error !== 1'b0)       begin n_mismatched++; $display("[TB] FAIL reset_error: got %b, required 0", error); end
        if (in_ready !== 1'b1)    begin n_mismatched++; $display("[TB] FAIL reset_in_ready: got %b, required 1", in_ready); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load(input string name, input int max_gap);
        do_reset();
        push_word(32'd2);
        push_word(32'h0000_0013);
        push_word(32'hDEAD_BEEF);
`ifdef IMEM_LOADER_CHECKSUM_EN
        push_word(32'hDEAD_BF02);
`endif
        sb.push_back({12'h000, 32'h0000_0013});
        sb.push_back({12'h004, 32'hDEAD_BEEF});
        send_image(max_gap);
        n_compared++;
        if (cpu_rst !== 1'b1) begin n_mismatched++; $display("[TB] FAIL %s_cpu_rst_hold: got %b, required 1", name, cpu_rst); end
        @(negedge clk);
        n_compared += 5;
        if (cpu_rst !== 1'b0)  begin n_mismatched++; $display("[TB] FAIL %s_cpu_rst_fall: got %b, required 0", name, cpu_rst); end
        if (done !== 1'b1)     begin n_mismatched++; $display("[TB] FAIL %s_done: got %b, required 1", name, done); end
        if (error !== 1'b0)    begin n_mismatched++; $display("[TB] FAIL %s_error: got %b, required 0", name, error); end
        if (in_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL %s_in_ready: got %b, required 0", name, in_ready); end
        if (sb.size() != 0)    begin n_mismatched++; $display("[TB] FAIL %s_writes_missing: got %0d pending, required 0", name, sb.size()); sb.delete(); end
    endtask

    task automatic test_zero_len();
        do_reset();
        push_word(32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        push_word(32'd0);
`endif
        send_image(0);
        n_compared++;
        if (cpu_rst !== 1'b1) begin n_mismatched++; $display("[TB] FAIL zero_cpu_rst_hold: got %b, required 1", cpu_rst); end
        @(negedge clk);
        n_compared += 3;
        if (cpu_rst !== 1'b0)  begin n_mismatched++; $display("[TB] FAIL zero_cpu_rst: got %b, required 0", cpu_rst); end
        if (done !== 1'b1)     begin n_mismatched++; $display("[TB] FAIL zero_done: got %b, required 1", done); end
        if (in_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL zero_in_ready: got %b, required 0", in_ready); end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hA0 + i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_compared += 2;
        if (done !== 1'b1 || cpu_rst !== 1'b0) begin n_mismatched++; $display("[TB] FAIL zero_after_bytes: got done=%b cpu_rst=%b, required 1/0", done, cpu_rst); end
        if (error !== 1'b0) begin n_mismatched++; $display("[TB] FAIL zero_error: got %b, required 0", error); end
    endtask

    task automatic test_too_long();
        do_reset();
        push_word(32'h0000_0401);
        send_image(0);
        @(negedge clk);
        n_compared += 4;
        if (error !== 1'b1)    begin n_mismatched++; $display("[TB] FAIL long_error: got %b, required 1", error); end
        if (cpu_rst !== 1'b1)  begin n_mismatched++; $display("[TB] FAIL long_cpu_rst: got %b, required 1", cpu_rst); end
        if (done !== 1'b0)     begin n_mismatched++; $display("[TB] FAIL long_done: got %b, required 0", done); end
        if (in_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL long_in_ready: got %b, required 0", in_ready); end
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_compared++;
        if (error !== 1'b1) begin n_mismatched++; $display("[TB] FAIL long_error_sticky: got %b, required 1", error); end
    endtask

    task automatic test_max_len();
        logic [31:0] w;
        logic [31:0] sum;
        do_reset();
        sum = '0;
        push_word(32'd1024);
        for (int i = 0; i < 1024; i++) begin
            w = 32'h9E37_79B9 * 32'(i + 1);
            push_word(w);
            sb.push_back({12'(i * 4), w});
            sum = sum + w;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        push_word(sum);
`endif
        send_image(0);
        repeat (2) @(negedge clk);
        n_compared += 3;
        if (done !== 1'b1)  begin n_mismatched++; $display("[TB] FAIL max_done: got %b, required 1", done); end
        if (error !== 1'b0) begin n_mismatched++; $display("[TB] FAIL max_error: got %b, required 0", error); end
        if (sb.size() != 0) begin n_mismatched++; $display("[TB] FAIL max_writes_missing: got %0d pending, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        push_word(32'd2);
        push_word(32'h0000_0013);
        img.push_back(8'hAA);
        img.push_back(8'hBB);
        sb.push_back({12'h000, 32'h0000_0013});
        send_image(0);
        rst = 1'b1;
        @(negedge clk);
        n_compared += 7;
        if (imem_we !== 1'b0)     begin n_mismatched++; $display("[TB] FAIL mid_we: got %b, required 0", imem_we); end
        if (imem_addr !== 12'h0)  begin n_mismatched++; $display("[TB] FAIL mid_addr: got %h, required 000", imem_addr); end
        if (imem_wdata !== 32'h0) begin n_mismatched++; $display("[TB] FAIL mid_wdata: got %h, required 0", imem_wdata); end
        if (cpu_rst !== 1'b1)     begin n_mismatched++; $display("[TB] FAIL mid_cpu_rst: got %b, required 1", cpu_rst); end
        if (done !== 1'b0)        begin n_mismatched++; $display("[TB] FAIL mid_done: got %b, required 0", done); end
        if (error !== 1'b0)       begin n_mismatched++; $display("[TB] FAIL mid_error: got %b, required 0", error); end
        if (sb.size() != 0)       begin n_mismatched++; $display("[TB] FAIL mid_word0_missing: got %0d pending, required 0", sb.size()); sb.delete(); end
        rst = 1'b0;
        @(negedge clk);
        push_word(32'd1);
        push_word(32'h1234_5678);
`ifdef IMEM_LOADER_CHECKSUM_EN
        push_word(32'h1234_5678);
`endif
        sb.push_back({12'h000, 32'h1234_5678});
        send_image(2);
        repeat (2) @(negedge clk);
        n_compared += 2;
        if (done !== 1'b1 || cpu_rst !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_reload_done: got done=%b cpu_rst=%b, required 1/0", done, cpu_rst); end
        if (sb.size() != 0) begin n_mismatched++; $display("[TB] FAIL mid_reload_missing: got %0d pending, required 0", sb.size()); sb.delete(); end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        for (int k = 0; k < 2; k++) begin
            do_reset();
            push_word(32'd2);
            push_word(32'h0000_0013);
            push_word(32'hDEAD_BEEF);
            push_word((k == 0) ? 32'hDEAD_BF02 : 32'hDEAD_BF03);
            sb.push_back({12'h000, 32'h0000_0013});
            sb.push_back({12'h004, 32'hDEAD_BEEF});
            send_image(1);
            repeat (2) @(negedge clk);
            n_compared += 4;
            if (done !== (k == 0))     begin n_mismatched++; $display("[TB] FAIL chk%0d_done: got %b, required %0d", k, done, k == 0); end
            if (error !== (k != 0))    begin n_mismatched++; $display("[TB] FAIL chk%0d_error: got %b, required %0d", k, error, k != 0); end
            if (cpu_rst !== (k != 0))  begin n_mismatched++; $display("[TB] FAIL chk%0d_cpu_rst: got %b, required %0d", k, cpu_rst, k != 0); end
            if (sb.size() != 0)        begin n_mismatched++; $display("[TB] FAIL chk%0d_writes_missing: got %0d pending, required 0", k, sb.size()); sb.delete(); end
        end
    endtask
`endif

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        test_reset();
        test_load("b2b", 0);
        test_reset();
        test_load("gaps", 3);
        test_zero_len();
        test_too_long();
        test_mid_reset();
        test_max_len();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
